// File: rtl/shift_xfer_engine.sv
// shift_xfer_engine: full-duplex, trigger-paced shift engine.
// A word loaded on start is serialised onto q while a word is assembled
// from sin, one bit per trigger tick, MSB-first or LSB-first per transfer.
//
// Handshake: start is level-sampled in IDLE and DONE; the cycle after an
// accepting edge busy is high and q carries the first bit. done is a
// one-cycle pulse, and dout is valid in that cycle and held until the next
// done or a reset.
module shift_xfer_engine #(
    parameter int unsigned N          = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trigger,
    input  logic         start,
    input  logic         lsb_first,
    input  logic [N-1:0] d,
    input  logic         sin,
    output logic         q,
    output logic         busy,
    output logic         last_tick,
    output logic         done,
    output logic [N-1:0] dout
);

    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  sreg_q,  sreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          order_q, order_d;
    logic [N-1:0]  dout_q,  dout_d;

    logic [N-1:0]  sreg_shift;
    logic          cnt_at_last;

    // Shift-register value after one bit period, in the latched bit order.
    always_comb begin
        sreg_shift = sreg_q;
        if (order_q) begin
            sreg_shift = {sin, sreg_q[N-1:1]};
        end else begin
            sreg_shift = {sreg_q[N-2:0], sin};
        end
    end

    assign cnt_at_last = (cnt_q == CNT_LAST);

    // Next-state logic: a trigger in the same cycle as an accepted start only
    // loads; it is not counted as a bit.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    sreg_d  = d;
                    order_d = lsb_first;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (trigger) begin
                    sreg_d = sreg_shift;
                    if (cnt_at_last) begin
                        // The captured word includes the final sin bit.
                        dout_d  = sreg_shift;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer without producing done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            dout_q  <= dout_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        busy      = (state_q == ST_SHIFT);
        done      = (state_q == ST_DONE);
        last_tick = busy && cnt_at_last;
        q         = IDLE_LEVEL;
        if (busy) begin
            q = order_q ? sreg_q[0] : sreg_q[N-1];
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_shift_xfer_engine.sv
// tb_shift_xfer_engine: directed scoreboard bench for shift_xfer_engine (N=8).
// Drivers push the expected q bits, last_tick levels and received words into
// queues; a negedge monitor pops and compares whenever the DUT shows a bit
// being clocked (busy && trigger) or a done pulse.
module tb_shift_xfer_engine;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         trigger;
    logic         start;
    logic         lsb_first;
    logic [W-1:0] d;
    logic         sin;
    logic         q;
    logic         busy;
    logic         last_tick;
    logic         done;
    logic [W-1:0] dout;

    logic         loop_en;
    logic         sin_drv;

    logic [W-1:0] exp_q[$];
    logic         bit_q[$];
    logic         lt_q[$];

    int checks;
    int failures;
    int done_cnt;

    assign sin = loop_en ? q : sin_drv;

    shift_xfer_engine #(.N(W), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .start     (start),
        .lsb_first (lsb_first),
        .d         (d),
        .sin       (sin),
        .q         (q),
        .busy      (busy),
        .last_tick (last_tick),
        .done      (done),
        .dout      (dout)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the bit on q at each clocked bit and dout at each done.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) begin
                if (lt_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL busy_unexpected: got busy=1 expected no transfer at %0t", $time);
                end else begin
                    check("last_tick", {31'b0, last_tick}, {31'b0, lt_q[0]});
                    if (trigger) begin
                        check("q_bit", {31'b0, q}, {31'b0, bit_q.pop_front()});
                        void'(lt_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got done=1 expected none at %0t", $time);
                end else begin
                    check("dout_at_done", {24'b0, dout}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    // Queue the expected q bit sequence for one word in the given order.
    task automatic push_bits(input logic [W-1:0] dv, input logic lsb);
        for (int k = 0; k < W; k++) begin
            bit_q.push_back(lsb ? dv[k] : dv[W-1-k]);
            lt_q.push_back(k == W - 1);
        end
    endtask

    // After a transfer: everything expected was observed, outputs idle, dout held.
    task automatic check_idle_after(input logic [W-1:0] exp_dout);
        @(negedge clk);
        check("done_seen", exp_q.size(), 0);
        check("bits_seen", bit_q.size(), 0);
        check("idle_busy", {31'b0, busy}, 0);
        check("idle_q", {31'b0, q}, 0);
        check("dout_held", {24'b0, dout}, {24'b0, exp_dout});
    endtask

    // One transfer: trigger every `period` cycles; optional start+trigger on
    // the accepting edge and an ignored start with d=FF/lsb_first=1 mid-shift.
    task automatic run_xfer(input logic [W-1:0] dv, input logic lsb, input logic loop,
                            input logic sin_c, input int period, input logic trig_at_start,
                            input logic noise);
        logic [W-1:0] exp_word;
        int n;
        int cyc;
        exp_word = loop ? dv : {W{sin_c}};
        push_bits(dv, lsb);
        exp_q.push_back(exp_word);
        @(posedge clk); #1;
        loop_en   = loop;
        sin_drv   = sin_c;
        start     = 1'b1;
        d         = dv;
        lsb_first = lsb;
        trigger   = trig_at_start;
        @(posedge clk); #1;
        start     = 1'b0;
        trigger   = 1'b0;
        d         = '0;
        lsb_first = 1'b0;
        n   = 0;
        cyc = 0;
        while (n < W) begin
            cyc++;
            trigger = ((cyc % period) == 0);
            if (noise && (cyc == 5 || cyc == 9)) begin
                start     = 1'b1;
                d         = 8'hFF;
                lsb_first = 1'b1;
            end else begin
                start     = 1'b0;
                lsb_first = 1'b0;
            end
            if (trigger) n++;
            @(posedge clk); #1;
        end
        trigger   = 1'b0;
        start     = 1'b0;
        lsb_first = 1'b0;
        @(posedge clk); #1;
        check_idle_after(exp_word);
    endtask

    initial begin
        int gap;
        int done_before;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        trigger   = 1'b0;
        start     = 1'b0;
        lsb_first = 1'b0;
        d         = '0;
        loop_en   = 1'b0;
        sin_drv   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_q", {31'b0, q}, 0);
        check("rst_last_tick", {31'b0, last_tick}, 0);
        check("rst_dout", {24'b0, dout}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MSB-first loopback of A5, trigger every 4th cycle
        run_xfer(8'hA5, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        // LSB-first, d=01, sin held high -> dout FF
        run_xfer(8'h01, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        // 3C MSB-first loopback with ignored start pulses mid-shift
        run_xfer(8'h3C, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1);

        // Triggers in IDLE are ignored
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            trigger = i[0];
            @(negedge clk);
            check("idle_trig_busy", {31'b0, busy}, 0);
            check("idle_trig_q", {31'b0, q}, 0);
        end
        @(posedge clk); #1;
        trigger = 1'b0;

        // start+trigger on the accepting edge: still exactly 8 bits
        run_xfer(8'h69, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0);

        // Back-to-back: start held, trigger tied high, loopback 96 then 5A
        push_bits(8'h96, 1'b0);
        push_bits(8'h5A, 1'b0);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        loop_en = 1'b1;
        start   = 1'b1;
        d       = 8'h96;
        trigger = 1'b1;
        @(posedge clk); #1;
        d   = 8'h5A;
        gap = 0;
        // First word occupies 8 SHIFT cycles, then one DONE cycle that
        // accepts the held start, then 8 more SHIFT cycles.
        for (int i = 0; i < 2 * W + 1; i++) begin
            @(negedge clk);
            if (!busy) gap++;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        trigger = 1'b0;
        d       = '0;
        check("b2b_busy_gap", gap, 1);
        @(posedge clk); #1;
        check_idle_after(8'h5A);

        // Reset at cnt=3 during a C3 transfer
        bit_q.push_back(1'b1); lt_q.push_back(1'b0);
        bit_q.push_back(1'b1); lt_q.push_back(1'b0);
        bit_q.push_back(1'b0); lt_q.push_back(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        d     = 8'hC3;
        @(posedge clk); #1;
        start   = 1'b0;
        d       = '0;
        trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        trigger = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_q", {31'b0, q}, 0);
        check("abort_last_tick", {31'b0, last_tick}, 0);
        check("abort_dout", {24'b0, dout}, 0);
        check("abort_bits_seen", bit_q.size(), 0);
        done_before = done_cnt;
        trigger = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        trigger = 1'b0;
        check("abort_no_done", done_cnt, done_before);

        // Restart after the abort: clean 81 transfer
        done_before = done_cnt;
        run_xfer(8'h81, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        check("restart_single_done", done_cnt, done_before + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
